// File: rtl/jtframe_mr_ddrarb.sv
// Burst-aware arbiter sharing the DDR3 Avalon-MM port between the ROM loader
// (read only) and the rotation frame buffer (read and write). The grant only
// moves between bursts, so a burst in flight is never cut or redirected.
module jtframe_mr_ddrarb #(
  parameter int AW = 29,
  parameter int DW = 64,
  parameter int BW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            downloading,
  // loader master
  input  logic [AW-1:0]   ld_addr,
  input  logic [BW-1:0]   ld_burstcnt,
  input  logic            ld_rd,
  input  logic [DW/8-1:0] ld_be,
  output logic            ld_busy,
  output logic            ld_dout_ready,
  // rotation master
  input  logic [AW-1:0]   rot_addr,
  input  logic [BW-1:0]   rot_burstcnt,
  input  logic            rot_rd,
  input  logic            rot_we,
  input  logic [DW/8-1:0] rot_be,
  input  logic [DW-1:0]   rot_din,
  output logic            rot_busy,
  output logic            rot_dout_ready,
  // DDR slave
  input  logic            ddr_busy,
  input  logic            ddr_dout_ready,
  output logic [AW-1:0]   ddr_addr,
  output logic [BW-1:0]   ddr_burstcnt,
  output logic            ddr_rd,
  output logic            ddr_we,
  output logic [DW/8-1:0] ddr_be,
  output logic [DW-1:0]   ddr_din
);

  typedef enum logic [1:0] {IDLE, LD_RD, ROT_RD, ROT_WR} state_t;

  localparam logic [BW-1:0] ONE = {{(BW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  // beats still owed in the current burst; zero means the command is not yet accepted
  logic [BW-1:0] left_q, left_d;
  // set when rot held the previous grant, so ld wins the next tie
  logic          last_q, last_d;

  logic [BW-1:0] ld_len, rot_len;
  logic          rot_req;

  // A zero burst count is handled as a single beat
  always_comb begin
    ld_len  = (ld_burstcnt  == '0) ? ONE : ld_burstcnt;
    rot_len = (rot_burstcnt == '0) ? ONE : rot_burstcnt;
    rot_req = rot_rd | rot_we;
  end

  // Steer the granted master onto the DDR port and mask the other one
  always_comb begin
    ddr_addr       = '0;
    ddr_burstcnt   = '0;
    ddr_rd         = 1'b0;
    ddr_we         = 1'b0;
    ddr_be         = '0;
    ddr_din        = '0;
    ld_busy        = 1'b1;
    rot_busy       = 1'b1;
    ld_dout_ready  = 1'b0;
    rot_dout_ready = 1'b0;
    case (state_q)
      LD_RD: begin
        ddr_addr      = ld_addr;
        ddr_burstcnt  = ld_burstcnt;
        ddr_be        = ld_be;
        ddr_rd        = ld_rd & (left_q == '0);
        ld_busy       = ddr_busy;
        ld_dout_ready = ddr_dout_ready & (left_q != '0);
      end
      ROT_RD: begin
        ddr_addr       = rot_addr;
        ddr_burstcnt   = rot_burstcnt;
        ddr_be         = rot_be;
        ddr_din        = rot_din;
        ddr_rd         = rot_rd & (left_q == '0);
        rot_busy       = ddr_busy;
        rot_dout_ready = ddr_dout_ready & (left_q != '0);
      end
      ROT_WR: begin
        ddr_addr     = rot_addr;
        ddr_burstcnt = rot_burstcnt;
        ddr_be       = rot_be;
        ddr_din      = rot_din;
        ddr_we       = rot_we;
        rot_busy     = ddr_busy;
      end
      default: ;
    endcase
  end

  // Arbitrate in IDLE and track burst progress in the granted states
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        left_d = '0;
        if (ld_rd && (downloading || !rot_req || last_q)) begin
          state_d = LD_RD;
          last_d  = 1'b0;
        end else if (rot_req) begin
          state_d = rot_we ? ROT_WR : ROT_RD;
          last_d  = 1'b1;
        end
      end
      LD_RD: begin
        if (left_q == '0) begin
          if (ld_rd && !ddr_busy) left_d = ld_len;
        end else if (ddr_dout_ready) begin
          left_d = left_q - ONE;
          if (left_q == ONE) state_d = IDLE;
        end
      end
      ROT_RD: begin
        if (left_q == '0) begin
          if (rot_rd && !ddr_busy) left_d = rot_len;
        end else if (ddr_dout_ready) begin
          left_d = left_q - ONE;
          if (left_q == ONE) state_d = IDLE;
        end
      end
      ROT_WR: begin
        if (rot_we && !ddr_busy) begin
          if (left_q == '0) begin
            left_d = rot_len - ONE;
            if (rot_len == ONE) state_d = IDLE;
          end else begin
            left_d = left_q - ONE;
            if (left_q == ONE) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, beat counter and round-robin memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      left_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_jtframe_mr_ddrarb.sv
// Self-checking bench for jtframe_mr_ddrarb: a table of single-grant
// vectors, directed multi-cycle sequences and a randomized run against a
// transaction-level model of two masters and a DDR slave.
module tb_jtframe_mr_ddrarb;

  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = 8;

  localparam logic [AW-1:0] LDA  = 29'h00ABC123;
  localparam logic [AW-1:0] ROTA = 29'h15550ABC;
  localparam logic [DW-1:0] RDIN = 64'hDEAD_BEEF_0123_4567;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            downloading = 1'b0;
  logic [AW-1:0]   ld_addr = '0;
  logic [BW-1:0]   ld_burstcnt = '0;
  logic            ld_rd = 1'b0;
  logic [DW/8-1:0] ld_be = '0;
  logic            ld_busy, ld_dout_ready;
  logic [AW-1:0]   rot_addr = '0;
  logic [BW-1:0]   rot_burstcnt = '0;
  logic            rot_rd = 1'b0;
  logic            rot_we = 1'b0;
  logic [DW/8-1:0] rot_be = '0;
  logic [DW-1:0]   rot_din = '0;
  logic            rot_busy, rot_dout_ready;
  logic            ddr_busy = 1'b0;
  logic            ddr_dout_ready = 1'b0;
  logic [AW-1:0]   ddr_addr;
  logic [BW-1:0]   ddr_burstcnt;
  logic            ddr_rd, ddr_we;
  logic [DW/8-1:0] ddr_be;
  logic [DW-1:0]   ddr_din;

  int checks = 0;
  int failures = 0;

  jtframe_mr_ddrarb #(.AW(AW), .DW(DW), .BW(BW)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ld_addr(ld_addr), .ld_burstcnt(ld_burstcnt), .ld_rd(ld_rd), .ld_be(ld_be),
    .ld_busy(ld_busy), .ld_dout_ready(ld_dout_ready),
    .rot_addr(rot_addr), .rot_burstcnt(rot_burstcnt), .rot_rd(rot_rd),
    .rot_we(rot_we), .rot_be(rot_be), .rot_din(rot_din),
    .rot_busy(rot_busy), .rot_dout_ready(rot_dout_ready),
    .ddr_busy(ddr_busy), .ddr_dout_ready(ddr_dout_ready),
    .ddr_addr(ddr_addr), .ddr_burstcnt(ddr_burstcnt), .ddr_rd(ddr_rd),
    .ddr_we(ddr_we), .ddr_be(ddr_be), .ddr_din(ddr_din)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    downloading = 0; ld_rd = 0; rot_rd = 0; rot_we = 0;
    ddr_busy = 0; ddr_dout_ready = 0;
    ld_addr = '0; ld_burstcnt = '0; ld_be = '0;
    rot_addr = '0; rot_burstcnt = '0; rot_be = '0; rot_din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    check_output({nm, "_ld_busy"}, ld_busy, 1);
    check_output({nm, "_rot_busy"}, rot_busy, 1);
    check_output({nm, "_rdwe"}, {ddr_rd, ddr_we}, 0);
    check_output({nm, "_addr"}, ddr_addr, 0);
    check_output({nm, "_din"}, ddr_din, 0);
  endtask

  // ---------------- table of single-grant vectors ----------------
  typedef struct {
    bit dl, ldr, rotr, rotw;
    bit eldb, erotb, erd, ewe;
    logic [AW-1:0] eaddr;
  } vec_t;

  task automatic run_table();
    vec_t vecs[8];
    vecs[0] = '{0,1,0,0, 0,1,1,0, LDA};
    vecs[1] = '{0,0,1,0, 1,0,1,0, ROTA};
    vecs[2] = '{0,0,0,1, 1,0,0,1, ROTA};
    vecs[3] = '{0,0,1,1, 1,0,0,1, ROTA};
    vecs[4] = '{0,1,1,0, 0,1,1,0, LDA};
    vecs[5] = '{1,1,0,1, 0,1,1,0, LDA};
    vecs[6] = '{1,0,1,0, 1,0,1,0, ROTA};
    vecs[7] = '{0,0,0,0, 1,1,0,0, '0};
    for (int i = 0; i < 8; i++) begin
      apply_reset();
      downloading = vecs[i].dl; ld_rd = vecs[i].ldr;
      rot_rd = vecs[i].rotr; rot_we = vecs[i].rotw;
      ld_addr = LDA; ld_burstcnt = 8'd2; rot_addr = ROTA; rot_burstcnt = 8'd2;
      rot_din = RDIN; ddr_busy = 0;
      #1 check_idle($sformatf("vec%0d_idle", i));
      nxt();
      check_output($sformatf("vec%0d_ld_busy", i), ld_busy, vecs[i].eldb);
      check_output($sformatf("vec%0d_rot_busy", i), rot_busy, vecs[i].erotb);
      check_output($sformatf("vec%0d_rd", i), ddr_rd, vecs[i].erd);
      check_output($sformatf("vec%0d_we", i), ddr_we, vecs[i].ewe);
      check_output($sformatf("vec%0d_addr", i), ddr_addr, vecs[i].eaddr);
      check_output($sformatf("vec%0d_din", i), ddr_din, (vecs[i].eaddr == ROTA) ? RDIN : 64'd0);
    end
  endtask

  // ---------------- directed multi-cycle sequences ----------------
  task automatic ld_read(input int cnt, input string nm);
    int n;
    n = (cnt == 0) ? 1 : cnt;
    ld_rd = 1; ld_addr = LDA; ld_burstcnt = 8'(cnt); ddr_busy = 1;
    nxt();
    check_output({nm, "_grant_rd"}, ddr_rd, 1);
    check_output({nm, "_wait_busy"}, ld_busy, 1);
    ddr_busy = 0;
    #1 check_output({nm, "_accept_busy"}, ld_busy, 0);
    nxt();
    ld_rd = 0;
    for (int b = 0; b < n; b++) begin
      ddr_dout_ready = 1;
      #1;
      check_output({nm, "_beat_ld"}, ld_dout_ready, 1);
      check_output({nm, "_beat_rot"}, rot_dout_ready, 0);
      check_output({nm, "_rd_after_accept"}, ddr_rd, 0);
      check_output({nm, "_still_granted"}, ld_busy, 0);
      nxt();
    end
    ddr_dout_ready = 0;
    #1 check_idle({nm, "_end"});
  endtask

  task automatic run_directed();
    // single reads of 4 beats and of a zero count, then a stray beat in IDLE
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      ld_read(k == 0 ? 4 : 0, k == 0 ? "ld4" : "ld0");
      ddr_dout_ready = 1;
      #1 check_output("stray_beat", {ld_dout_ready, rot_dout_ready}, 0);
      nxt();
      ddr_dout_ready = 0;
    end
    // downloading drops during an ld burst of 8; rot waits for the full burst
    apply_reset();
    downloading = 1; ld_rd = 1; ld_addr = LDA; ld_burstcnt = 8'd8;
    rot_rd = 1; rot_addr = ROTA; rot_burstcnt = 8'd2;
    nxt();
    check_output("dl_grant_addr", ddr_addr, LDA);
    nxt();
    ld_rd = 0; downloading = 0;
    for (int b = 0; b < 8; b++) begin
      ddr_dout_ready = 1;
      #1 check_output("dl_beat_route", {ld_dout_ready, rot_dout_ready}, 2'b10);
      nxt();
    end
    ddr_dout_ready = 0;
    #1 check_idle("dl_gap");
    nxt();
    check_output("dl_rot_addr", ddr_addr, ROTA);
    check_output("dl_rot_busy", rot_busy, 0);
    check_output("dl_rot_rd", ddr_rd, 1);
    // reset in the middle of a rot write, then a fresh ld read
    apply_reset();
    rot_we = 1; rot_addr = ROTA; rot_burstcnt = 8'd8; rot_be = 8'hF0;
    nxt();
    for (int b = 0; b < 3; b++) begin
      rot_din = RDIN + 64'(b);
      #1;
      check_output("wr_we", ddr_we, 1);
      check_output("wr_din", ddr_din, RDIN + 64'(b));
      check_output("wr_be", ddr_be, 8'hF0);
      nxt();
    end
    rst = 1;
    #1 check_idle("rst_mid");
    check_output("rst_mid_be", ddr_be, 0);
    rot_we = 0;
    nxt();
    rst = 0;
    ld_read(2, "post_rst");
  endtask

  // ---------------- randomized run with transaction model ----------------
  int ld_id, ld_cnt, ld_wait; bit ld_pend;
  int rot_id, rot_cnt, rot_b, rot_wait; bit rot_pend, rot_isw;
  int owed, wleft, wlen, grants; bit sown;
  logic [AW-1:0] waddr;

  function automatic int blen(input int c);
    return (c == 0) ? 1 : c;
  endfunction

  task automatic new_ld();
    ld_id++; ld_pend = 1; ld_cnt = $urandom_range(0, 4); ld_wait = 0;
  endtask

  task automatic new_rot();
    rot_id++; rot_pend = 1; rot_cnt = $urandom_range(0, 4); rot_b = 0; rot_wait = 0;
    rot_isw = $urandom_range(0, 1) == 1;
  endtask

  task automatic grant_seen(input bit dl, input string nm);
    bit exp_rot;
    exp_rot = dl ? 1'b0 : (grants % 2 == 1);
    check_output({nm, "_owner"}, ddr_addr[AW-1], exp_rot);
    grants++;
  endtask

  task automatic apply_stimulus(input bit dl, input int ncyc);
    int len;
    apply_reset();
    downloading = dl;
    ld_id = 0; rot_id = 1000; owed = 0; wleft = 0; grants = 0; sown = 0;
    new_ld(); new_rot();
    for (int i = 0; i < ncyc; i++) begin
      ld_rd = ld_pend; ld_addr = {1'b0, 28'(ld_id)}; ld_burstcnt = 8'(ld_cnt); ld_be = 8'(ld_id);
      rot_rd = rot_pend && !rot_isw;
      rot_we = rot_pend && rot_isw && !(rot_b > 0 && $urandom_range(0, 3) == 0);
      rot_addr = {1'b1, 28'(rot_id)}; rot_burstcnt = 8'(rot_cnt);
      rot_din = {32'(rot_id), 32'(rot_b)}; rot_be = 8'(rot_id) ^ 8'h5A;
      ddr_busy = $urandom_range(0, 2) == 0;
      ddr_dout_ready = (owed > 0) && ($urandom_range(0, 1) == 1);
      #1;
      // DDR slave view
      check_output("rnd_rd_we_excl", ddr_rd & ddr_we, 0);
      if (ddr_dout_ready) begin
        check_output("rnd_beat_route", {ld_dout_ready, rot_dout_ready}, sown ? 2'b01 : 2'b10);
        owed--;
      end else begin
        check_output("rnd_no_beat", {ld_dout_ready, rot_dout_ready}, 0);
      end
      if (ddr_rd && !ddr_busy) begin
        check_output("rnd_rd_overlap", (owed == 0) && (wleft == 0), 1);
        grant_seen(dl, "rnd_rd");
        sown = ddr_addr[AW-1];
        owed = blen(int'(ddr_burstcnt));
      end
      if (ddr_we && !ddr_busy) begin
        if (wleft == 0) begin
          check_output("rnd_wr_overlap", owed == 0, 1);
          grant_seen(dl, "rnd_wr");
          waddr = ddr_addr; wlen = blen(int'(ddr_burstcnt)); wleft = wlen;
        end
        check_output("rnd_wr_addr", ddr_addr, waddr);
        check_output("rnd_wr_din", ddr_din, {32'(waddr[AW-2:0]), 32'(wlen - wleft)});
        check_output("rnd_wr_be", ddr_be, 8'(waddr[7:0]) ^ 8'h5A);
        wleft--;
      end
      // master views
      if (ld_rd && !ld_busy) begin
        ld_pend = 0; ld_wait = blen(ld_cnt);
      end else if (ld_dout_ready) begin
        check_output("rnd_ld_extra_beat", ld_wait > 0, 1);
        ld_wait--;
        if (ld_wait <= 0) new_ld();
      end
      if (rot_rd && !rot_busy) begin
        rot_pend = 0; rot_wait = blen(rot_cnt);
      end else if (rot_dout_ready) begin
        check_output("rnd_rot_extra_beat", rot_wait > 0, 1);
        rot_wait--;
        if (rot_wait <= 0) new_rot();
      end
      if (rot_we && !rot_busy) begin
        rot_b++;
        if (rot_b == blen(rot_cnt)) new_rot();
      end
      nxt();
    end
    check_output("rnd_progress", grants >= 10, 1);
  endtask

  initial begin
    run_table();
    run_directed();
    apply_stimulus(1'b0, 1500);
    apply_stimulus(1'b1, 600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_mr_ddrarb.md
Name: jtframe_mr_ddrarb

Overview:
- Burst-aware arbiter sharing the MiSTer DDR3 Avalon-MM port between two requesters: the fast ROM loader (ld, read-only) and the vertical-rotation frame buffer (rot, read and write).
- Replaces a plain steering mux. Grant changes only between bursts, so no transfer is ever corrupted when `downloading` toggles or both masters request together.
- Sits between the loader/rotation blocks and the HPS DDR interface.

Parameters:
AW, 29, DDR word address width
DW, 64, DDR data width
BW, 8, burst count width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
downloading  in  1  ROM download in progress; gives ld absolute priority
ld_addr  in  AW  loader burst start address
ld_burstcnt  in  BW  loader burst length
ld_rd  in  1  loader read request
ld_be  in  DW/8  loader byte enables
ld_busy  out  1  waitrequest to loader
ld_dout_ready  out  1  read beat valid for loader
rot_addr  in  AW  rotation burst start address
rot_burstcnt  in  BW  rotation burst length
rot_rd  in  1  rotation read request
rot_we  in  1  rotation write beat
rot_be  in  DW/8  rotation byte enables
rot_din  in  DW  rotation write data
rot_busy  out  1  waitrequest to rotation
rot_dout_ready  out  1  read beat valid for rotation
ddr_busy  in  1  DDR waitrequest
ddr_dout_ready  in  1  DDR read beat valid (ddr_dout routed externally to both)
ddr_addr  out  AW  DDR address
ddr_burstcnt  out  BW  DDR burst count
ddr_rd  out  1  DDR read
ddr_we  out  1  DDR write
ddr_be  out  DW/8  DDR byte enables
ddr_din  out  DW  DDR write data

Behaviour:
- States: IDLE, LD_RD, ROT_RD, ROT_WR. The state register and an 8-bit beat counter `left` are reset asynchronously to IDLE and 0.
- IDLE outputs:
  - ddr_rd=0, ddr_we=0.
  - ddr_addr, ddr_burstcnt, ddr_be, ddr_din are 0.
  - ld_busy=1, rot_busy=1.
  - Both *_dout_ready=0.
  - These are also the values during reset.
- Arbitration (in IDLE, registered; the grant is visible the next cycle):
  - ld_rd and downloading both high: LD_RD.
  - Otherwise ld_rd and rot_rd|rot_we both high: round-robin. The requester not granted last wins. `last` resets to rot, so ld wins the first tie.
  - Single requester: grant it. A rot request goes to ROT_WR if rot_we, else ROT_RD.
  - rot_rd and rot_we both high: treated as a write.
- Granted state:
  - The granted master's addr, burstcnt, be, din and rd/we drive the ddr_* outputs combinationally.
  - The non-granted master's rd/we is masked.
  - Granted busy = ddr_busy. Non-granted busy = 1.
- Command accept: the cycle with rd|we high and ddr_busy=0 while `left`==0 (first beat). On accept, load `left` with burstcnt. burstcnt=0 is treated as 1.
- LD_RD / ROT_RD:
  - After accept, ddr_rd is forced 0.
  - ddr_dout_ready is forwarded only to the granted master.
  - Each beat decrements `left`. The beat taking `left` from 1 to 0 returns the block to IDLE on the next edge.
- ROT_WR:
  - Each beat with rot_we=1 and ddr_busy=0 decrements `left` (the first beat loads burstcnt-1).
  - Reaching 0 returns the block to IDLE.
  - rot_we low mid-burst stalls the burst; the grant is held.
- Exactly one dead IDLE cycle separates consecutive bursts. A burst is never pre-empted: a `downloading` change mid-burst takes effect at the next arbitration.
- ddr_dout_ready seen in IDLE, e.g. stray beats after reset, is dropped.
- Reset mid-burst: IDLE immediately. The DDR side is expected to be reset by the same source.

Test Plan:
- Single ld read, burstcnt=4, ddr_busy=0 one cycle at accept, 4 dout_ready beats -> ddr_rd high exactly 1 cycle, ld_dout_ready pulses 4 times, rot_dout_ready never; IDLE 1 cycle after beat 4.
- rot write burstcnt=3 with ddr_busy high 2 cycles on beat 2 -> 3 accepted beats; ddr_din/be follow rot_din/be; ddr_we low after beat 3.
- Both requesting continuously, downloading=0, burstcnt=2 each -> grants alternate ld, rot, ld, rot; no DDR command overlaps an unfinished burst.
- downloading=1 with rot requesting -> every grant goes to ld. downloading falls during an ld burst of 8 -> all 8 beats go to ld, then rot is granted.
- burstcnt=0 read -> handled as 1 beat. ddr_dout_ready pulsed in IDLE -> neither dout_ready asserts.
- Assert rst mid ROT_WR (left=5) -> next cycle all ddr_* low, both busy=1. After release, new ld read of 2 completes normally.
